// File: rtl/pacman_pkg.sv
// pacman_pkg: shared command/direction encodings, scan states and maze defaults.
package pacman_pkg;
  localparam int GRID_W_DEF = 21;
  localparam int GRID_H_DEF = 21;
  typedef enum logic [1:0] {MODE_ABS = 2'b00, MODE_STEP = 2'b01, MODE_RESP = 2'b10, MODE_NOP = 2'b11} wr_mode_e;
  typedef enum logic [1:0] {DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11} dir_e;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_EMIT, SCAN_DONE} scan_state_e;
endpackage

// File: rtl/entity_position_file_coord_step.sv
// coord_step: one-tile increment/decrement of a coordinate with tunnel wrap at 0 and LIMIT-1.
module coord_step #(
  parameter int W = 5,
  parameter int LIMIT = 21
) (
  input  logic [W-1:0] c,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);
  localparam logic [W-1:0] MAX = W'(LIMIT - 1);
  always_comb nxt = inc ? (c == MAX ? '0 : c + 1'b1) : dec ? (c == '0 ? MAX : c - 1'b1) : c;
endmodule

// File: rtl/entity_position_file.sv
// entity_position_file: per-entity maze positions with write/step/respawn, read port,
// renderer scan stream and registered Pacman-ghost collision detection.
module entity_position_file import pacman_pkg::*; #(
  parameter int NUM_ENTITIES = 5,
  localparam int ID_W = $clog2(NUM_ENTITIES),
  parameter int X_WIDTH = 5,
  parameter int Y_WIDTH = 5,
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter logic [NUM_ENTITIES*X_WIDTH-1:0] HOME_X = {5'd18, 5'd2, 5'd18, 5'd2, 5'd10},
  parameter logic [NUM_ENTITIES*Y_WIDTH-1:0] HOME_Y = {5'd18, 5'd18, 5'd2, 5'd2, 5'd15}
) (
  input  logic               clock_50,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [ID_W-1:0]    wr_id,
  input  logic [1:0]         wr_mode,
  input  logic [1:0]         wr_dir,
  input  logic [X_WIDTH-1:0] wr_x,
  input  logic [Y_WIDTH-1:0] wr_y,
  output logic               wr_err,
  input  logic [ID_W-1:0]    rd_id,
  output logic [X_WIDTH-1:0] rd_x,
  output logic [Y_WIDTH-1:0] rd_y,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_valid,
  input  logic               scan_ready,
  output logic [ID_W-1:0]    scan_id,
  output logic [X_WIDTH-1:0] scan_x,
  output logic [Y_WIDTH-1:0] scan_y,
  output logic               scan_done,
  output logic               collision,
  output logic [ID_W-1:0]    collision_id
);
  localparam logic [ID_W:0]    N    = (ID_W + 1)'(NUM_ENTITIES);
  localparam logic [ID_W-1:0]  LAST = ID_W'(NUM_ENTITIES - 1);
  localparam logic [X_WIDTH:0] GW   = (X_WIDTH + 1)'(GRID_W);
  localparam logic [Y_WIDTH:0] GH   = (Y_WIDTH + 1)'(GRID_H);
  logic [X_WIDTH-1:0] x_q [NUM_ENTITIES];
  logic [X_WIDTH-1:0] x_d [NUM_ENTITIES];
  logic [Y_WIDTH-1:0] y_q [NUM_ENTITIES];
  logic [Y_WIDTH-1:0] y_d [NUM_ENTITIES];
  logic [X_WIDTH-1:0] rd_x_q, rd_x_d, step_x, sx_q, sx_d;
  logic [Y_WIDTH-1:0] rd_y_q, rd_y_d, step_y, sy_q, sy_d;
  logic [ID_W-1:0]    wsel, sid_q, sid_d, nid, coll_id_q, coll_id_d;
  logic               wr_err_q, wr_err_d, coll_q, coll_d, id_ok, rd_ok, in_grid;
  wr_mode_e           mode;
  dir_e               dir;
  scan_state_e        st_q, st_d;
  assign mode    = wr_mode_e'(wr_mode);
  assign dir     = dir_e'(wr_dir);
  assign id_ok   = {1'b0, wr_id} < N;
  assign rd_ok   = {1'b0, rd_id} < N;
  assign wsel    = id_ok ? wr_id : '0;
  assign in_grid = {1'b0, wr_x} < GW && {1'b0, wr_y} < GH;
  assign nid     = sid_q + 1'b1;
  coord_step #(.W(X_WIDTH), .LIMIT(GRID_W)) u_step_x (
    .c(x_q[wsel]), .inc(dir == DIR_RIGHT), .dec(dir == DIR_LEFT), .nxt(step_x)
  );
  coord_step #(.W(Y_WIDTH), .LIMIT(GRID_H)) u_step_y (
    .c(y_q[wsel]), .inc(dir == DIR_DOWN), .dec(dir == DIR_UP), .nxt(step_y)
  );
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    wr_err_d = wr_en && mode != MODE_NOP && (!id_ok || (mode == MODE_ABS && !in_grid));
    if (wr_en && id_ok && !wr_err_d && mode != MODE_NOP) begin
      x_d[wsel] = mode == MODE_ABS ? wr_x : mode == MODE_STEP ? step_x : HOME_X[wsel*X_WIDTH +: X_WIDTH];
      y_d[wsel] = mode == MODE_ABS ? wr_y : mode == MODE_STEP ? step_y : HOME_Y[wsel*Y_WIDTH +: Y_WIDTH];
    end
    rd_x_d = rd_ok ? x_q[rd_id] : '0;
    rd_y_d = rd_ok ? y_q[rd_id] : '0;
  end
  // Highest index scanned first so the lowest colliding ghost wins.
  always_comb begin
    coll_id_d = '0;
    for (int i = NUM_ENTITIES - 1; i >= 1; i--)
      if (x_q[i] == x_q[0] && y_q[i] == y_q[0]) coll_id_d = ID_W'(i);
    coll_d = coll_id_d != '0;
  end
  always_comb begin
    st_d = st_q;
    sid_d = sid_q;
    sx_d = sx_q;
    sy_d = sy_q;
    if (st_q == SCAN_IDLE && scan_start) begin
      st_d = SCAN_EMIT;
      sid_d = '0;
      sx_d = x_q[0];
      sy_d = y_q[0];
    end else if (st_q == SCAN_EMIT && scan_ready) begin
      if (sid_q == LAST) st_d = SCAN_DONE;
      else begin
        sid_d = nid;
        sx_d = x_q[nid];
        sy_d = y_q[nid];
      end
    end else if (st_q == SCAN_DONE) st_d = SCAN_IDLE;
  end
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTITIES; i++) begin
        x_q[i] <= HOME_X[i*X_WIDTH +: X_WIDTH];
        y_q[i] <= HOME_Y[i*Y_WIDTH +: Y_WIDTH];
      end
      rd_x_q <= '0;
      rd_y_q <= '0;
      wr_err_q <= 1'b0;
      coll_q <= 1'b0;
      coll_id_q <= '0;
      st_q <= SCAN_IDLE;
      sid_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      rd_x_q <= rd_x_d;
      rd_y_q <= rd_y_d;
      wr_err_q <= wr_err_d;
      coll_q <= coll_d;
      coll_id_q <= coll_id_d;
      st_q <= st_d;
      sid_q <= sid_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end
  assign wr_err       = wr_err_q;
  assign rd_x         = rd_x_q;
  assign rd_y         = rd_y_q;
  assign scan_busy    = st_q == SCAN_EMIT;
  assign scan_valid   = st_q == SCAN_EMIT;
  assign scan_done    = st_q == SCAN_DONE;
  assign scan_id      = sid_q;
  assign scan_x       = sx_q;
  assign scan_y       = sy_q;
  assign collision    = coll_q;
  assign collision_id = coll_id_q;
endmodule

// File: tb/tb_entity_position_file.sv
// tb_entity_position_file: directed plus randomized checks against a behavioural position model.
module tb_entity_position_file;
  localparam int NE = 5, GW = 21, GH = 21;
  logic clk = 0, rst_n = 0;
  logic wr_en = 0, scan_start = 0, scan_ready = 0;
  logic [2:0] wr_id = 0, rd_id = 0;
  logic [1:0] wr_mode = 3, wr_dir = 0;
  logic [4:0] wr_x = 0, wr_y = 0;
  logic wr_err, scan_busy, scan_valid, scan_done, collision;
  logic [4:0] rd_x, rd_y, scan_x, scan_y;
  logic [2:0] scan_id, collision_id;
  int checks = 0, failures = 0, done_cnt;
  int hx[NE] = '{10, 2, 18, 2, 18};
  int hy[NE] = '{15, 2, 2, 18, 18};
  int mx[NE], my[NE];
  int e_rx, e_ry, e_err, e_coll, e_cid, b_id, b_x, b_y;
  bit sc_on, sc_done;

  entity_position_file dut (
    .clock_50(clk), .reset_n(rst_n), .wr_en(wr_en), .wr_id(wr_id), .wr_mode(wr_mode),
    .wr_dir(wr_dir), .wr_x(wr_x), .wr_y(wr_y), .wr_err(wr_err), .rd_id(rd_id),
    .rd_x(rd_x), .rd_y(rd_y), .scan_start(scan_start), .scan_busy(scan_busy),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_id(scan_id), .scan_x(scan_x),
    .scan_y(scan_y), .scan_done(scan_done), .collision(collision), .collision_id(collision_id)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int ox[NE], oy[NE];
    @(posedge clk);
    ox = mx;
    oy = my;
    if (!rst_n) begin
      mx = hx;
      my = hy;
      {e_rx, e_ry, e_err, e_coll, e_cid, b_id, b_x, b_y} = '0;
      sc_on = 0;
      sc_done = 0;
    end else begin
      e_rx = ox[rd_id];
      e_ry = oy[rd_id];
      e_err = 0;
      if (wr_en && wr_mode != 3) begin
        if (wr_id >= NE) e_err = 1;
        else if (wr_mode == 0) begin
          if (wr_x < GW && wr_y < GH) begin mx[wr_id] = wr_x; my[wr_id] = wr_y; end
          else e_err = 1;
        end else if (wr_mode == 1) begin
          if (wr_dir == 0) my[wr_id] = (oy[wr_id] + GH - 1) % GH;
          if (wr_dir == 1) my[wr_id] = (oy[wr_id] + 1) % GH;
          if (wr_dir == 2) mx[wr_id] = (ox[wr_id] + GW - 1) % GW;
          if (wr_dir == 3) mx[wr_id] = (ox[wr_id] + 1) % GW;
        end else begin
          mx[wr_id] = hx[wr_id];
          my[wr_id] = hy[wr_id];
        end
      end
      e_cid = 0;
      for (int i = NE - 1; i >= 1; i--) if (ox[i] == ox[0] && oy[i] == oy[0]) e_cid = i;
      e_coll = e_cid != 0;
      if (sc_done) sc_done = 0;
      else if (!sc_on && scan_start) begin sc_on = 1; b_id = 0; b_x = ox[0]; b_y = oy[0]; end
      else if (sc_on && scan_ready) begin
        if (b_id == NE - 1) begin sc_on = 0; sc_done = 1; end
        else begin b_id++; b_x = ox[b_id]; b_y = oy[b_id]; end
      end
    end
    #1;
    chk("rd_x", rd_x, e_rx);
    chk("rd_y", rd_y, e_ry);
    chk("wr_err", wr_err, e_err);
    chk("collision", collision, e_coll);
    chk("collision_id", collision_id, e_cid);
    chk("scan_valid", scan_valid, sc_on);
    chk("scan_busy", scan_busy, sc_on);
    chk("scan_done", scan_done, sc_done);
    if (sc_on) begin
      chk("scan_id", scan_id, b_id);
      chk("scan_x", scan_x, b_x);
      chk("scan_y", scan_y, b_y);
    end
    if (scan_done) done_cnt++;
  endtask

  task automatic cmd(input int id, input int mode, input int dir, input int x, input int y);
    wr_en = 1; wr_id = 3'(id); wr_mode = 2'(mode); wr_dir = 2'(dir); wr_x = 5'(x); wr_y = 5'(y);
    step();
    wr_en = 0;
  endtask

  initial begin
    step();
    step();
    rst_n = 1;
    for (int i = 0; i < NE; i++) begin
      rd_id = 3'(i);
      step();
      chk("home_x", rd_x, hx[i]);
      chk("home_y", rd_y, hy[i]);
    end
    chk("reset_coll", collision, 0);
    cmd(1, 0, 0, 20, 5);
    cmd(1, 1, 3, 0, 0);
    cmd(2, 0, 0, 3, 0);
    cmd(2, 1, 0, 0, 0);
    chk("step_err", wr_err, 0);
    rd_id = 1;
    step();
    chk("wrap_right_x", rd_x, 0);
    chk("wrap_right_y", rd_y, 5);
    rd_id = 2;
    step();
    chk("wrap_up_x", rd_x, 3);
    chk("wrap_up_y", rd_y, 20);
    cmd(3, 0, 0, 21, 4);
    chk("abs_oob_err", wr_err, 1);
    step();
    chk("err_one_cycle", wr_err, 0);
    cmd(5, 2, 0, 0, 0);
    chk("bad_id_err", wr_err, 1);
    rd_id = 3;
    step();
    chk("id3_kept_x", rd_x, 2);
    chk("id3_kept_y", rd_y, 18);
    cmd(2, 0, 0, 10, 15);
    cmd(4, 0, 0, 10, 15);
    step();
    chk("coll_lowest", collision_id, 2);
    cmd(2, 2, 0, 0, 0);
    step();
    chk("coll_after_respawn", collision_id, 4);
    done_cnt = 0;
    scan_ready = 1;
    scan_start = 1;
    step();
    scan_start = 0;
    step();
    step();
    chk("beat2_id", scan_id, 2);
    scan_ready = 0;
    for (int i = 0; i < 3; i++) cmd(2, 0, 0, 7 + i, 9);
    scan_ready = 1;
    for (int i = 0; i < 4; i++) step();
    chk("done_once", done_cnt, 1);
    scan_start = 1;
    step();
    scan_start = 0;
    for (int i = 0; i < 3; i++) step();
    chk("beat3_id", scan_id, 3);
    rst_n = 0;
    step();
    chk("abort_valid", scan_valid, 0);
    rst_n = 1;
    scan_start = 1;
    step();
    scan_start = 0;
    chk("restart_id", scan_id, 0);
    for (int n = 0; n < 4000; n++) begin
      rst_n = $urandom_range(0, 299) != 0;
      wr_en = $urandom_range(0, 1);
      wr_id = 3'($urandom_range(0, 7));
      wr_mode = 2'($urandom_range(0, 3));
      wr_dir = 2'($urandom_range(0, 3));
      wr_x = 5'($urandom_range(0, 31));
      wr_y = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin wr_x = 5'(mx[0]); wr_y = 5'(my[0]); end
      rd_id = 3'($urandom_range(0, NE - 1));
      scan_start = $urandom_range(0, 7) == 0;
      scan_ready = $urandom_range(0, 2) != 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/entity_position_file.md
# entity_position_file

Parametrised position store for every moving entity on the Pacman maze: entity 0 is Pacman, entities 1..NUM_ENTITIES-1 are ghosts. It supports absolute writes, single-tile steps with tunnel wrap-around, and respawn to per-entity home tiles. It also provides a registered random-read port, a valid/ready scan stream feeding the renderer, and a registered Pacman-ghost collision flag for the game FSM.

## Interface
Parameters:
- NUM_ENTITIES, 5, entity count (2..16); ID_W = $clog2(NUM_ENTITIES) derived
- X_WIDTH, 5, x coordinate width
- Y_WIDTH, 5, y coordinate width
- GRID_W, 21, legal x range 0..GRID_W-1 (GRID_W <= 2^X_WIDTH)
- GRID_H, 21, legal y range 0..GRID_H-1
- HOME_X, {18,2,18,2,10}, packed NUM_ENTITIES*X_WIDTH home x (entity 0 in LSBs)
- HOME_Y, {18,18,2,2,15}, packed home y

Ports:
- clock_50  in  1  clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  1  command strobe, one command per cycle
- wr_id  in  ID_W  target entity
- wr_mode  in  2  00 absolute, 01 step, 10 respawn, 11 nop
- wr_dir  in  2  step direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- wr_x / wr_y  in  X_WIDTH / Y_WIDTH  absolute target
- wr_err  out  1  one-cycle pulse on rejected command
- rd_id  in  ID_W  read select
- rd_x / rd_y  out  X_WIDTH / Y_WIDTH  registered read data
- scan_start  in  1  begin stream of all entities
- scan_busy  out  1  stream in progress
- scan_valid / scan_ready  out / in  1  stream handshake
- scan_id, scan_x, scan_y  out  ID_W, X_WIDTH, Y_WIDTH  stream beat
- scan_done  out  1  one-cycle pulse after last beat accepted
- collision  out  1  some ghost shares Pacman's tile
- collision_id  out  ID_W  lowest-index colliding ghost, 0 if none

## Operation
- Reset (reset_n=0 at an edge): every entity returns to HOME. rd_x/rd_y=0. All scan outputs are 0, and the FSM enters IDLE. collision=0, collision_id=0, wr_err=0.
- Absolute mode: if wr_x<GRID_W and wr_y<GRID_H, the entity is loaded. Otherwise there is no change and wr_err pulses.
- Step mode: moves one tile with wrap-around. x=GRID_W-1 stepping right becomes 0; x=0 stepping left becomes GRID_W-1. The same rule applies to y with GRID_H. The other coordinate is unchanged.
- Respawn mode: the entity is loaded with its HOME value.
- A wr_id of NUM_ENTITIES or more is ignored and pulses wr_err, whatever the mode. Nop never errors.
- Scan FSM states are IDLE, EMIT and DONE.
  - IDLE: scan_start moves to EMIT, loads a beat for id 0, and sets busy=valid=1.
  - EMIT: when a beat is accepted (valid&&ready) and it is not the last beat, the next id's live position loads on that edge. When the last beat is accepted, the FSM goes to DONE with valid=0.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
  - scan_start outside IDLE is ignored.
- A beat's data is captured at load and held stable while valid&&!ready. Writes during the hold do not alter the held beat.
- Collision is computed from the stored positions and registered. It sets when any ghost i>=1 has both x and y equal to entity 0's.

## Timing
- A write at edge t is visible in storage after t. rd_x/rd_y show the entity selected at edge t after t+1, a 1-cycle latency that reflects storage as it was before edge t.
- wr_err is high for the cycle following the offending edge only.
- A write and a read or scan of the same entity in the same cycle returns the old value.
- collision lags the position change by 1 cycle. A position written at edge t yields collision after edge t+1.
- Scan handshake: with scan_start at edge t, the first beat is valid after t. With ready held high, beats last one cycle each, so NUM_ENTITIES cycles in total. done follows the last accepted beat by one cycle.
- reset_n low mid-scan aborts the scan: valid, busy and done all go to 0 with no done pulse.

## Structure
- Shared package pacman_pkg: wr_mode encoding, direction encoding, default GRID_W/GRID_H. Extend it if it already exists.
- Sub-module coord_step: combinational next-coordinate computation with wrap, parametrised by width and limit. Instantiate it once for x and once for y.
- Storage: per-entity x/y register arrays. Collision: priority encoder over ghost compare vector.

## Test plan
- Reset, then read ids 0..4 -> (10,15),(2,2),(18,2),(2,18),(18,18). collision=0.
- Entity 1 at (20,5) steps right -> (0,5). Entity 2 at (3,0) steps up -> (3,20). No wr_err.
- Absolute write id 3 to (21,4) -> no change and a single-cycle wr_err. A write with wr_id=5 -> wr_err, storage unchanged.
- Move ghost 2 and ghost 4 onto Pacman's (10,15) -> collision=1 one cycle later with collision_id=2. Respawn ghost 2 -> collision_id=4.
- Scan with ready stalled 3 cycles on beat 2 while entity 2 is rewritten -> beat 2 data held unchanged. Ids stream 0..4. done pulses once, with busy low in the same cycle.
- reset_n low during beat 3 -> valid, busy and done all 0 next cycle, positions back to HOME, and a subsequent scan_start restarts at id 0.
